// File: rtl/up_dn_counter_seq.sv
// Command sequencer for a saturating up/down counter: LOAD / UP-by-N / DOWN-by-N / GOTO.
// Optional Abort input is enabled with `define UP_DN_SEQ_ABORT_EN.
module up_dn_counter_seq #(
   parameter int WIDTH = 5
) (
   input  logic             CLK,
   input  logic             RST,
`ifdef UP_DN_SEQ_ABORT_EN
   input  logic             Abort,
`endif
   input  logic             Cmd_Valid,
   output logic             Cmd_Ready,
   input  logic [1:0]       Cmd_Op,
   input  logic [WIDTH-1:0] Cmd_Arg,
   input  logic [WIDTH-1:0] Counter,
   input  logic             High,
   input  logic             Low,
   output logic [WIDTH-1:0] IN,
   output logic             Load,
   output logic             Up,
   output logic             Down,
   output logic             Busy,
   output logic             Done,
   output logic             Sat
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_UP,
      S_DOWN,
      S_GOTO,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_arg;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] w_rem_nxt;
   logic             r_sat;
   logic             w_sat_nxt;
   logic             w_accept;
   logic             w_abort;
   logic             w_rem_zero;
   logic             w_rem_one;

`ifdef UP_DN_SEQ_ABORT_EN
   assign w_abort = Abort;
`else
   assign w_abort = 1'b0;
`endif

   assign Cmd_Ready  = (r_state == S_IDLE) && !RST;
   assign w_accept   = Cmd_Valid && Cmd_Ready;
   assign w_rem_zero = (r_rem == '0);
   assign w_rem_one  = (r_rem == WIDTH'(1));

   assign Busy = (r_state != S_IDLE);
   assign Done = (r_state == S_DONE);
   assign Sat  = r_sat;
   assign IN   = r_arg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_arg   <= '0;
         r_rem   <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
         r_sat   <= w_sat_nxt;
         if (w_accept) r_arg <= Cmd_Arg;
      end
   end

   // UP/DOWN finish on the edge that consumes the last step, so N steps give
   // Done right after the Nth control cycle; a bound costs one extra cycle.
   always_comb begin
      Load        = 1'b0;
      Up          = 1'b0;
      Down        = 1'b0;
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_sat_nxt   = r_sat;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_rem_nxt = Cmd_Arg;
               case (Cmd_Op)
                  2'b00:   w_state_nxt = S_LOAD;
                  2'b01:   w_state_nxt = S_UP;
                  2'b10:   w_state_nxt = S_DOWN;
                  default: w_state_nxt = S_GOTO;
               endcase
            end
         end
         S_LOAD: begin
            Load        = !w_abort;
            w_state_nxt = S_DONE;
            w_sat_nxt   = 1'b0;
         end
         S_UP: begin
            Up = !w_abort && !w_rem_zero && !High;
            if (Up) w_rem_nxt = r_rem - WIDTH'(1);
            if (w_abort) begin
               w_state_nxt = S_DONE;
               w_sat_nxt   = 1'b0;
            end else if (w_rem_zero || High || (Up && w_rem_one)) begin
               w_state_nxt = S_DONE;
               w_sat_nxt   = High && !w_rem_zero;
            end
         end
         S_DOWN: begin
            Down = !w_abort && !w_rem_zero && !Low;
            if (Down) w_rem_nxt = r_rem - WIDTH'(1);
            if (w_abort) begin
               w_state_nxt = S_DONE;
               w_sat_nxt   = 1'b0;
            end else if (w_rem_zero || Low || (Down && w_rem_one)) begin
               w_state_nxt = S_DONE;
               w_sat_nxt   = Low && !w_rem_zero;
            end
         end
         S_GOTO: begin
            Up   = !w_abort && (Counter < r_arg);
            Down = !w_abort && (Counter > r_arg);
            if (w_abort || (Counter == r_arg)) begin
               w_state_nxt = S_DONE;
               w_sat_nxt   = 1'b0;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_up_dn_counter_seq.sv
// Directed bench for up_dn_counter_seq driving a behavioural saturating counter.
// Abort scenario is compiled in with `define UP_DN_SEQ_ABORT_EN.
module tb_up_dn_counter_seq;

   logic       CLK = 1'b0;
   logic       RST;
   logic       Cmd_Valid;
   logic       Cmd_Ready;
   logic [1:0] Cmd_Op;
   logic [4:0] Cmd_Arg;
   logic [4:0] cnt = 5'd0;
   logic       High, Low;
   logic [4:0] IN;
   logic       Load, Up, Down, Busy, Done, Sat;
`ifdef UP_DN_SEQ_ABORT_EN
   logic       Abort;
`endif

   int passed = 0;
   int total  = 0;
   int n_up = 0, n_dn = 0, n_ld = 0, n_multi = 0;

   always #5 CLK = ~CLK;

   assign High = (cnt == 5'd31);
   assign Low  = (cnt == 5'd0);

   up_dn_counter_seq #(.WIDTH(5)) dut (
      .CLK(CLK), .RST(RST),
`ifdef UP_DN_SEQ_ABORT_EN
      .Abort(Abort),
`endif
      .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op), .Cmd_Arg(Cmd_Arg),
      .Counter(cnt), .High(High), .Low(Low), .IN(IN),
      .Load(Load), .Up(Up), .Down(Down), .Busy(Busy), .Done(Done), .Sat(Sat)
   );

   // Counter model: Load beats Down beats Up, saturating, no reset.
   always @(posedge CLK) begin
      if (Load) cnt <= IN;
      else if (Down) begin if (cnt != 5'd0) cnt <= cnt - 5'd1; end
      else if (Up) begin if (cnt != 5'd31) cnt <= cnt + 5'd1; end
   end

   always @(negedge CLK) begin
      if (Up) n_up++;
      if (Down) n_dn++;
      if (Load) n_ld++;
      if ((int'(Up) + int'(Down) + int'(Load)) > 1) n_multi++;
   end

   task automatic issue(input logic [1:0] op, input logic [4:0] arg, input bit hold);
      int k = 0;
      @(negedge CLK);
      Cmd_Valid = 1'b1; Cmd_Op = op; Cmd_Arg = arg;
      while (!Cmd_Ready && k < 50) begin @(negedge CLK); k++; end
      @(posedge CLK);
      #1 if (!hold) Cmd_Valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output logic sat);
      cyc = -1;
      sat = 1'bx;
      for (int i = 1; i <= 60; i++) begin
         @(negedge CLK);
         if (Done) begin cyc = i; sat = Sat; break; end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; Cmd_Valid = 1'b0; Cmd_Op = 2'b00; Cmd_Arg = 5'd0;
      repeat (2) @(negedge CLK);
      total++; if ({Load, Up, Down} !== 3'b000) $display("FAIL rst_ctrl: got %b want 000", {Load, Up, Down}); else passed++;
      total++; if ({Busy, Done, Sat} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {Busy, Done, Sat}); else passed++;
      total++; if (Cmd_Ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", Cmd_Ready); else passed++;
      total++; if (IN !== 5'd0) $display("FAIL rst_in: got %0d want 0", IN); else passed++;
      RST = 1'b0;
      #1;
      total++; if (Cmd_Ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", Cmd_Ready); else passed++;
   endtask

   task automatic test_load_down();
      int c, l0, d0; logic s;
      l0 = n_ld;
      issue(2'b00, 5'd5, 0); wait_done(c, s);
      total++; if (c !== 2) $display("FAIL load_cyc: got %0d want 2", c); else passed++;
      total++; if (cnt !== 5'd5) $display("FAIL load_cnt: got %0d want 5", cnt); else passed++;
      total++; if (n_ld - l0 !== 1) $display("FAIL load_pulses: got %0d want 1", n_ld - l0); else passed++;
      d0 = n_dn;
      issue(2'b10, 5'd3, 0); wait_done(c, s);
      total++; if (c !== 4) $display("FAIL down3_cyc: got %0d want 4", c); else passed++;
      total++; if (n_dn - d0 !== 3) $display("FAIL down3_pulses: got %0d want 3", n_dn - d0); else passed++;
      total++; if (cnt !== 5'd2) $display("FAIL down3_cnt: got %0d want 2", cnt); else passed++;
      total++; if (s !== 1'b0) $display("FAIL down3_sat: got %b want 0", s); else passed++;
   endtask

   task automatic test_saturate();
      int c, u0, d0; logic s;
      issue(2'b00, 5'd28, 0); wait_done(c, s);
      u0 = n_up;
      issue(2'b01, 5'd10, 0); wait_done(c, s);
      total++; if (c !== 5) $display("FAIL upsat_cyc: got %0d want 5", c); else passed++;
      total++; if (n_up - u0 !== 3) $display("FAIL upsat_pulses: got %0d want 3", n_up - u0); else passed++;
      total++; if (cnt !== 5'd31) $display("FAIL upsat_cnt: got %0d want 31", cnt); else passed++;
      total++; if (s !== 1'b1) $display("FAIL upsat_sat: got %b want 1", s); else passed++;
      @(negedge CLK);
      total++; if (Sat !== 1'b1) $display("FAIL sat_hold: got %b want 1", Sat); else passed++;
      // exact landing on MAX is a normal finish
      issue(2'b00, 5'd29, 0); wait_done(c, s);
      issue(2'b01, 5'd2, 0); wait_done(c, s);
      total++; if (c !== 3) $display("FAIL upexact_cyc: got %0d want 3", c); else passed++;
      total++; if (s !== 1'b0) $display("FAIL upexact_sat: got %b want 0", s); else passed++;
      issue(2'b00, 5'd2, 0); wait_done(c, s);
      d0 = n_dn;
      issue(2'b10, 5'd5, 0); wait_done(c, s);
      total++; if (c !== 4) $display("FAIL dnsat_cyc: got %0d want 4", c); else passed++;
      total++; if (n_dn - d0 !== 2) $display("FAIL dnsat_pulses: got %0d want 2", n_dn - d0); else passed++;
      total++; if ({cnt, s} !== {5'd0, 1'b1}) $display("FAIL dnsat_cnt_sat: got %0d/%b want 0/1", cnt, s); else passed++;
   endtask

   task automatic test_goto();
      int c, u0, d0; logic s;
      issue(2'b00, 5'd4, 0); wait_done(c, s);
      u0 = n_up; d0 = n_dn;
      issue(2'b11, 5'd20, 0); wait_done(c, s);
      total++; if (c !== 18) $display("FAIL goto20_cyc: got %0d want 18", c); else passed++;
      total++; if ({n_up - u0, n_dn - d0} !== {32'sd16, 32'sd0}) $display("FAIL goto20_pulses: got up %0d dn %0d want 16/0", n_up - u0, n_dn - d0); else passed++;
      total++; if ({cnt, s} !== {5'd20, 1'b0}) $display("FAIL goto20_cnt_sat: got %0d/%b want 20/0", cnt, s); else passed++;
      u0 = n_up; d0 = n_dn;
      issue(2'b11, 5'd0, 0); wait_done(c, s);
      total++; if (c !== 22) $display("FAIL goto0_cyc: got %0d want 22", c); else passed++;
      total++; if ({n_up - u0, n_dn - d0} !== {32'sd0, 32'sd20}) $display("FAIL goto0_pulses: got up %0d dn %0d want 0/20", n_up - u0, n_dn - d0); else passed++;
      total++; if ({cnt, s} !== {5'd0, 1'b0}) $display("FAIL goto0_cnt_sat: got %0d/%b want 0/0", cnt, s); else passed++;
   endtask

   task automatic test_zero_steps();
      int c, u0, d0; logic s;
      issue(2'b00, 5'd9, 0); wait_done(c, s);
      u0 = n_up; d0 = n_dn;
      issue(2'b01, 5'd0, 0); wait_done(c, s);
      total++; if (c !== 2) $display("FAIL up0_cyc: got %0d want 2", c); else passed++;
      issue(2'b10, 5'd0, 0); wait_done(c, s);
      total++; if (c !== 2) $display("FAIL dn0_cyc: got %0d want 2", c); else passed++;
      issue(2'b11, 5'd9, 0); wait_done(c, s);
      total++; if (c !== 2) $display("FAIL gotosame_cyc: got %0d want 2", c); else passed++;
      total++; if (s !== 1'b0) $display("FAIL gotosame_sat: got %b want 0", s); else passed++;
      total++; if ({n_up - u0, n_dn - d0} !== {32'sd0, 32'sd0}) $display("FAIL zero_pulses: got up %0d dn %0d want 0/0", n_up - u0, n_dn - d0); else passed++;
      total++; if (cnt !== 5'd9) $display("FAIL zero_cnt: got %0d want 9", cnt); else passed++;
   endtask

   task automatic test_busy_hold();
      int c, u0; logic s;
      u0 = n_up;
      issue(2'b01, 5'd3, 1);
      @(negedge CLK);
      total++; if ({Busy, Cmd_Ready} !== 2'b10) $display("FAIL busy_ready: got %b want 10", {Busy, Cmd_Ready}); else passed++;
      wait_done(c, s);
      total++; if (c !== 3) $display("FAIL hold_cyc: got %0d want 3", c); else passed++;
      total++; if (Cmd_Ready !== 1'b0) $display("FAIL done_ready: got %b want 0", Cmd_Ready); else passed++;
      Cmd_Valid = 1'b0;
      total++; if (n_up - u0 !== 3) $display("FAIL hold_pulses: got %0d want 3", n_up - u0); else passed++;
      total++; if (cnt !== 5'd12) $display("FAIL hold_cnt: got %0d want 12", cnt); else passed++;
      @(negedge CLK);
      total++; if (Cmd_Ready !== 1'b1) $display("FAIL post_done_ready: got %b want 1", Cmd_Ready); else passed++;
   endtask

   task automatic test_reset_mid();
      int c; logic s;
      issue(2'b00, 5'd2, 0); wait_done(c, s);
      issue(2'b01, 5'd10, 0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      #1;
      total++; if ({Load, Up, Down} !== 3'b000) $display("FAIL midrst_ctrl: got %b want 000", {Load, Up, Down}); else passed++;
      total++; if ({Busy, Cmd_Ready} !== 2'b00) $display("FAIL midrst_busy_ready: got %b want 00", {Busy, Cmd_Ready}); else passed++;
      @(posedge CLK); #1;
      total++; if (cnt !== 5'd4) $display("FAIL midrst_cnt: got %0d want 4", cnt); else passed++;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      total++; if ({Busy, Cmd_Ready} !== 2'b01) $display("FAIL midrst_release: got %b want 01", {Busy, Cmd_Ready}); else passed++;
      @(posedge CLK); #1;
      total++; if (cnt !== 5'd4) $display("FAIL midrst_cnt_hold: got %0d want 4", cnt); else passed++;
   endtask

`ifdef UP_DN_SEQ_ABORT_EN
   task automatic test_abort();
      int c; logic s;
      issue(2'b00, 5'd10, 0); wait_done(c, s);
      issue(2'b01, 5'd15, 0);
      repeat (4) @(negedge CLK);
      @(negedge CLK);
      Abort = 1'b1;
      #1;
      total++; if (Up !== 1'b0) $display("FAIL abort_gate: got %b want 0", Up); else passed++;
      @(negedge CLK);
      Abort = 1'b0;
      total++; if ({Done, Sat} !== 2'b10) $display("FAIL abort_done_sat: got %b want 10", {Done, Sat}); else passed++;
      total++; if (cnt !== 5'd14) $display("FAIL abort_cnt: got %0d want 14", cnt); else passed++;
   endtask
`endif

   initial begin
`ifdef UP_DN_SEQ_ABORT_EN
      Abort = 1'b0;
`endif
      test_reset();
      test_load_down();
      test_saturate();
      test_goto();
      test_zero_steps();
      test_busy_hold();
      test_reset_mid();
`ifdef UP_DN_SEQ_ABORT_EN
      test_abort();
`endif
      total++; if (n_multi !== 0) $display("FAIL one_hot_ctrl: got %0d overlaps want 0", n_multi); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/up_dn_counter_seq.md
# up_dn_counter_seq

Command sequencer for the Up_Dn_Counter. It accepts LOAD / UP-by-N / DOWN-by-N / GOTO-target commands over a valid/ready handshake and drives the counter's IN, Load, Up and Down controls cycle by cycle. It watches the counter's Counter, High and Low outputs to finish or saturate each command, then reports completion. It sits between a host/control FSM and a single counter instance, so requesters never toggle counter controls directly.

## Interface
- WIDTH, 5: counter width; MAX = 2^WIDTH-1.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Cmd_Valid  in  1  command present.
- Cmd_Ready  out  1  sequencer can accept; = (state==IDLE) && !RST.
- Cmd_Op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 GOTO.
- Cmd_Arg  in  WIDTH  load value / step count / target.
- Counter  in  WIDTH  counter value.
- High  in  1  counter == MAX.
- Low  in  1  counter == 0.
- IN  out  WIDTH  counter load value.
- Load  out  1  counter load strobe.
- Up  out  1  counter increment enable.
- Down  out  1  counter decrement enable.
- Busy  out  1  state != IDLE.
- Done  out  1  one-cycle completion pulse.
- Sat  out  1  valid with Done; command stopped at a bound before finishing.
- Abort  in  1  only with UP_DN_SEQ_ABORT_EN.

## Operation
- Counter contract: Load beats Down, Down beats Up, and the counter saturates at 0 and MAX.
- The sequencer never asserts more than one of Load/Up/Down at a time.
- States: IDLE, LOAD, UP, DOWN, GOTO, DONE.
- Accept: Cmd_Valid && Cmd_Ready at a CLK edge. At that edge, latch Cmd_Arg into arg_q and rem_q, then go to the op state.
- LOAD:
  - IN = arg_q and Load = 1 for exactly one cycle.
  - Then DONE with Sat = 0.
- UP:
  - Up = (rem_q != 0) && !High.
  - rem_q decrements on each cycle Up = 1.
  - Go to DONE when rem_q == 0 or High == 1.
  - Sat = 1 if High ended the command with rem_q != 0.
- DOWN: mirror of UP using Low and Down.
- GOTO:
  - Up = (Counter < arg_q).
  - Down = (Counter > arg_q).
  - Go to DONE when Counter == arg_q. Sat = 0.
- DONE: Done = 1 for one cycle, then IDLE.
- Sat holds its value until the next Done.
- Control outputs are combinational from registered state, rem_q, arg_q and the counter inputs only. There is no path from Cmd_* to the controls.
- IN = arg_q in every state; it is only meaningful while Load = 1.
- Cmd_Valid while busy is not accepted. The requester holds the command until Cmd_Ready.
- Step count 0 (UP/DOWN), or GOTO with target == Counter: zero control cycles, then DONE on the next edge, Sat = 0.
- Unsigned compare, WIDTH bits. rem_q is WIDTH bits and never wraps, because it is only decremented when nonzero.

## Timing
- Accept edge = E0.
- LOAD:
  - Load high during E0..E1.
  - Counter == arg at E1.
  - Done during E1..E2.
  - Cmd_Ready again after E2.
- UP/DOWN N, no saturation:
  - Control high for exactly N cycles.
  - Counter updated at E1..EN.
  - Done during EN..EN+1.
  - Next accept earliest at EN+2.
- Saturating UP from start s: exactly MAX-s Up cycles, then one cycle with High = 1 and Up = 0, then Done.
- GOTO: |target - start| control cycles, then one check cycle, then Done.
- Reset:
  - State = IDLE.
  - Load, Up, Down, Done, Sat, Busy, Cmd_Ready = 0; IN = 0 (arg_q cleared).
  - Mid-command reset drops all controls immediately. The counter keeps its value; it has no reset.

## Configuration
- UP_DN_SEQ_ABORT_EN:
  - Defined: Abort port exists. Abort = 1 in LOAD/UP/DOWN/GOTO gates all controls to 0 that same cycle, so no further step or load occurs. Next edge goes to DONE with Done pulse and Sat = 0. Abort in IDLE/DONE is ignored.
  - Undefined: no Abort port; commands always run to completion.

## Test plan
- RST pulse mid-UP:
  - Controls 0 in the same cycle.
  - Busy = 0, Cmd_Ready = 1 after release.
  - Counter value unchanged by the sequencer.
- LOAD 5, then DOWN 3:
  - Counter 5 after LOAD.
  - Exactly 3 Down cycles, Counter = 2, Done with Sat = 0.
- LOAD 28, then UP 10:
  - 3 Up cycles, Counter = 31.
  - Done with Sat = 1.
- LOAD 4, then GOTO 20 → 16 Up cycles, Counter = 20. Then GOTO 0 → 20 Down cycles, Counter = 0. Both Sat = 0.
- UP 0 and GOTO to current value:
  - No Up/Down pulses.
  - Done the cycle after accept.
  - Cmd_Valid held during Busy is not accepted.
- With UP_DN_SEQ_ABORT_EN, from Counter 10, UP 15 with Abort after 4 Up cycles:
  - Counter = 14.
  - Done next cycle, Sat = 0.
